mmul_loader: RTL and testbench
==============================

MMUL_LOADER -- requirements
Module: mmul_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one matrix/vector element.
REQ-002 Parameter N, default 8: elements per A row, and length of vector B.
REQ-003 Parameter M, default 8: number of A rows, equal to the number of A FIFOs.
REQ-004 Parameter N_WIDTH, default $clog2(N): column counter width.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-006 i_clk  input  1  clock; all state updates on its rising edge.
REQ-007 i_rst  input  1  asynchronous, active-high reset.
REQ-008 i_start  input  1  one-cycle request to begin a load; honoured only in IDLE.
REQ-009 i_data  input  DATA_WIDTH  source element stream.
REQ-010 i_valid  input  1  i_data holds a valid element.
REQ-011 o_ready  output  1  loader accepts i_data this cycle.
REQ-012 o_a  output  DATA_WIDTH*M  A write data; lane r occupies bits [r*DATA_WIDTH +: DATA_WIDTH].
REQ-013 o_a_valid  output  M  one-hot write strobe to A FIFO r.
REQ-014 i_a_full  input  M  full flag of A FIFO r.
REQ-015 o_b  output  DATA_WIDTH  B FIFO write data.
REQ-016 o_b_valid  output  1  B FIFO write strobe.
REQ-017 i_b_full  input  1  B FIFO full flag.
REQ-018 o_clr  output  1  one-cycle clear pulse to the multiplier/FIFO block.
REQ-019 o_busy  output  1  high in every state except IDLE.
REQ-020 o_done  output  1  one-cycle pulse when a load completes.

Function
REQ-021 States SHALL be IDLE, CLR, LOAD_B, LOAD_A and DONE, held in a registered state variable.
- IDLE to CLR on i_start.
- CLR to LOAD_B unconditionally, after 1 cycle.
- LOAD_B to LOAD_A after the N-th B transfer.
- LOAD_A to DONE after the N-th transfer of row M-1.
- DONE to IDLE unconditionally, after 1 cycle.
REQ-022 o_clr SHALL be 1 exactly while in CLR; o_done SHALL be 1 exactly while in DONE.
REQ-023 o_ready SHALL be combinational:
- in LOAD_B: !i_b_full;
- in LOAD_A: !i_a_full[row];
- in all other states: 0.
REQ-024 A transfer occurs in a cycle where i_valid and o_ready are both 1; nothing is transferred otherwise.
REQ-025 o_b SHALL equal i_data (combinational), and o_b_valid SHALL be 1 only on a transfer in LOAD_B.
REQ-026 Every o_a lane SHALL carry i_data, and o_a_valid SHALL equal (1 << row) only on a transfer in LOAD_A, else 0.
REQ-027 At most one FIFO strobe (o_b_valid or one bit of o_a_valid) SHALL be high per cycle.
REQ-028 A strobe SHALL never be asserted to a FIFO whose full flag is high in that cycle.
REQ-029 Column counter col (N_WIDTH bits):
- increments on each transfer;
- wraps from N-1 to 0;
- is cleared in CLR.
REQ-030 Row counter row ($clog2(M) bits, minimum 1):
- increments when col wraps in LOAD_A;
- is cleared in CLR.
REQ-031 Element order is fixed: N B elements, then A row 0 elements 0..N-1, then row 1, and so on through row M-1; exactly N*(M+1) transfers per load.
REQ-032 A full flag rising mid-row SHALL stall the load with col and row held, and the load SHALL resume on the next cycle in which the flag is low.
REQ-033 i_valid low SHALL stall the load without changing any state.
REQ-034 i_start asserted while not in IDLE SHALL be ignored.
REQ-035 i_start asserted in the DONE cycle SHALL be ignored.
REQ-036 Full flags of non-selected FIFOs SHALL not affect o_ready.

Reset
REQ-037 While i_rst is 1, the block SHALL be in IDLE with col=0 and row=0.
REQ-038 While i_rst is 1, all outputs SHALL be 0: o_ready, o_a_valid, o_b_valid, o_clr, o_busy and o_done.
REQ-039 Reset SHALL take effect immediately, without waiting for a clock edge.
REQ-040 Reset asserted mid-load SHALL abandon the load with no o_done pulse.
REQ-041 After reset deasserts, the block SHALL require a fresh i_start before any transfer.

Verification (N=M=8, DATA_WIDTH=8)
REQ-042 Basic load: i_start pulse, then 72 back-to-back elements 0..71 with i_valid=1 and all FIFOs empty. Required response:
- o_clr for 1 cycle;
- elements 0..7 on o_b_valid;
- elements 8..15 on o_a_valid=8'h01, and so on, elements 64..71 on o_a_valid=8'h80;
- o_done 1 cycle after the 72nd transfer;
- 75 cycles in total from i_start to return to IDLE.
REQ-043 Stall on full: i_a_full[3]=1 after 2 elements of row 3 have been written. Required response:
- o_ready=0 and no strobes while the flag is high;
- col=2 held;
- on release, the next element goes to lane 3 with col 2.
REQ-044 Source bubbles: i_valid toggled every other cycle. Required response: the same data order as REQ-042 and 72 strobes in total.
REQ-045 Start while busy: i_start pulsed during LOAD_A. Required response: no o_clr pulse and no change to row or col.
REQ-046 Reset mid-load: i_rst asserted after 20 transfers. Required response:
- all outputs 0 at once, and no o_done;
- a following i_start produces a full 72-transfer load starting at the B elements.
REQ-047 Unselected full: i_a_full[7]=1 during the B phase and row 0. Required response: o_ready stays 1 and the load proceeds normally.

Source files
------------

// File: rtl/mmul_loader.sv
// Matrix-multiply loader: streams N B elements then M rows of N A elements
// from one source into the B FIFO and the per-row A FIFOs.
module mmul_loader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned N          = 8,
    parameter int unsigned M          = 8,
    parameter int unsigned N_WIDTH    = $clog2(N)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [DATA_WIDTH-1:0]      i_data,
    input  logic                       i_valid,
    output logic                       o_ready,
    output logic [DATA_WIDTH*M-1:0]    o_a,
    output logic [M-1:0]               o_a_valid,
    input  logic [M-1:0]               i_a_full,
    output logic [DATA_WIDTH-1:0]      o_b,
    output logic                       o_b_valid,
    input  logic                       i_b_full,
    output logic                       o_clr,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int unsigned          R_WIDTH  = (M > 1) ? $clog2(M) : 1;
    localparam logic [N_WIDTH-1:0]   COL_LAST = N_WIDTH'(N - 1);
    localparam logic [R_WIDTH-1:0]   ROW_LAST = R_WIDTH'(M - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD_B,
        S_LOAD_A,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [N_WIDTH-1:0]   col_q, col_d;
    logic [R_WIDTH-1:0]   row_q, row_d;
    logic                 xfer;
    logic                 col_last;

    // Data fans out to every sink; only the strobes select the destination.
    assign o_b = i_data;
    assign o_a = {M{i_data}};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        o_ready   = 1'b0;
        o_b_valid = 1'b0;
        o_a_valid = '0;
        o_clr     = 1'b0;
        o_busy    = 1'b1;
        o_done    = 1'b0;
        xfer      = 1'b0;
        col_last  = (col_q == COL_LAST);

        case (state_q)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                o_clr   = 1'b1;
                col_d   = '0;
                row_d   = '0;
                state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                o_ready   = !i_b_full;
                xfer      = i_valid && o_ready;
                o_b_valid = xfer;
                if (xfer) begin
                    col_d = col_last ? '0 : col_q + N_WIDTH'(1);
                    if (col_last) begin
                        state_d = S_LOAD_A;
                    end
                end
            end
            S_LOAD_A: begin
                // Only the FIFO of the row being written gates the source.
                o_ready = !i_a_full[row_q];
                xfer    = i_valid && o_ready;
                if (xfer) begin
                    o_a_valid = M'(1) << row_q;
                    col_d     = col_last ? '0 : col_q + N_WIDTH'(1);
                    if (col_last) begin
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + R_WIDTH'(1);
                        if (row_q == ROW_LAST) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mmul_loader.sv
// Self-checking bench for mmul_loader (N=M=8, DATA_WIDTH=8): control vector
// table plus scoreboarded full loads with stalls, bubbles, restart and reset.
module tb_mmul_loader;

    localparam int unsigned DW = 8;
    localparam int unsigned NN = 8;
    localparam int unsigned MM = 8;
    localparam int          TOTAL = 72;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_start;
    logic [DW-1:0]      i_data;
    logic               i_valid;
    logic               o_ready;
    logic [DW*MM-1:0]   o_a;
    logic [MM-1:0]      o_a_valid;
    logic [MM-1:0]      i_a_full;
    logic [DW-1:0]      o_b;
    logic               o_b_valid;
    logic               i_b_full;
    logic               o_clr;
    logic               o_busy;
    logic               o_done;

    mmul_loader #(.DATA_WIDTH(DW), .N(NN), .M(MM)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_data(i_data),
        .i_valid(i_valid), .o_ready(o_ready), .o_a(o_a), .o_a_valid(o_a_valid),
        .i_a_full(i_a_full), .o_b(o_b), .o_b_valid(o_b_valid), .i_b_full(i_b_full),
        .o_clr(o_clr), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic           is_b;
        logic [MM-1:0]  mask;
        logic [DW-1:0]  data;
    } exp_t;

    typedef struct {
        logic           rst, start, valid;
        logic [MM-1:0]  a_full;
        logic           b_full;
        logic           ready, b_valid, busy, clr, done;
    } vec_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ready"},   32'(o_ready),   32'd0);
        check({tag, " a_valid"}, 32'(o_a_valid), 32'd0);
        check({tag, " b_valid"}, 32'(o_b_valid), 32'd0);
        check({tag, " clr"},     32'(o_clr),     32'd0);
        check({tag, " busy"},    32'(o_busy),    32'd0);
        check({tag, " done"},    32'(o_done),    32'd0);
    endtask

    // mode: 0 basic, 1 stall on A[3], 2 source bubbles, 3 start while busy,
    //       4 reset after 20 transfers, 5 unselected A[7] full early
    task automatic run_load(input int mode, input string tag);
        int   idx;
        int   cyc;
        int   stall_left;
        int   row;
        bit   vld;
        bit   exp_ready;
        bit   strobe;
        bit   aborted;
        exp_t e;

        exp_q.delete();
        for (int k = 0; k < TOTAL; k++) begin
            e.is_b = (k < NN);
            e.mask = (k < NN) ? '0 : MM'(1) << ((k - NN) / NN);
            e.data = DW'(k);
            exp_q.push_back(e);
        end

        @(posedge i_clk); #1;
        i_start  = 1'b1;
        i_valid  = 1'b0;
        i_a_full = '0;
        i_b_full = 1'b0;
        @(negedge i_clk);
        check({tag, " idle busy"}, 32'(o_busy), 32'd0);
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(negedge i_clk);
        check({tag, " clr"},       32'(o_clr),   32'd1);
        check({tag, " clr busy"},  32'(o_busy),  32'd1);
        check({tag, " clr ready"}, 32'(o_ready), 32'd0);
        @(posedge i_clk); #1;

        idx        = 0;
        cyc        = 2;
        stall_left = 3;
        aborted    = 1'b0;
        while (idx < TOTAL && !aborted) begin
            if (cyc > 400) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s timeout: got %0d transfers expected %0d", tag, idx, TOTAL);
                break;
            end
            vld      = (mode == 2) ? (cyc % 2 == 0) : 1'b1;
            i_valid  = vld;
            i_data   = DW'(idx);
            i_a_full = '0;
            i_b_full = 1'b0;
            if (mode == 1 && idx == NN + 3 * NN + 2 && stall_left > 0) begin
                i_a_full[3] = 1'b1;
                stall_left--;
            end
            if (mode == 5 && idx < 2 * NN) i_a_full[7] = 1'b1;
            i_start = (mode == 3 && idx == 20);

            if (mode == 4 && idx == 20) begin
                i_rst = 1'b1;
                #1;
                check_all_zero({tag, " async"});
                aborted = 1'b1;
            end else begin
                @(negedge i_clk);
                row       = (idx < NN) ? 0 : (idx - NN) / NN;
                exp_ready = (idx < NN) ? !i_b_full : !i_a_full[row];
                check({tag, " ready"}, 32'(o_ready), 32'(exp_ready));
                check({tag, " clr low"},  32'(o_clr),  32'd0);
                check({tag, " done low"}, 32'(o_done), 32'd0);
                check({tag, " busy"},     32'(o_busy), 32'd1);
                if (mode == 1 && i_a_full[3]) begin
                    check({tag, " held col"}, 32'(dut.col_q), 32'd2);
                    check({tag, " held row"}, 32'(dut.row_q), 32'd3);
                end
                strobe = o_b_valid || (o_a_valid != '0);
                check({tag, " strobe"}, 32'(strobe), 32'(vld && exp_ready));
                if (strobe) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL %s extra strobe: got a_valid %0h b_valid %0b expected none",
                                 tag, o_a_valid, o_b_valid);
                    end else begin
                        e = exp_q.pop_front();
                        check({tag, " b_valid"}, 32'(o_b_valid), 32'(e.is_b));
                        check({tag, " a_valid"}, 32'(o_a_valid), 32'(e.mask));
                        if (e.is_b) check({tag, " b data"}, 32'(o_b), 32'(e.data));
                        else        check({tag, " a data"}, 32'(o_a[row*DW +: DW]), 32'(e.data));
                    end
                end
                if (vld && exp_ready) idx++;
                @(posedge i_clk); #1;
                cyc++;
            end
        end

        i_valid  = 1'b0;
        i_start  = 1'b0;
        i_a_full = '0;
        if (aborted) begin
            @(negedge i_clk);
            check_all_zero({tag, " held rst"});
            @(posedge i_clk); #1;
            i_rst   = 1'b0;
            i_valid = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge i_clk);
                check({tag, " no start ready"}, 32'(o_ready), 32'd0);
                check({tag, " no start strobes"}, 32'({o_b_valid, o_a_valid}), 32'd0);
                check({tag, " no start busy"}, 32'(o_busy), 32'd0);
                @(posedge i_clk); #1;
            end
            i_valid = 1'b0;
        end else begin
            @(negedge i_clk);
            check({tag, " done"},       32'(o_done),  32'd1);
            check({tag, " done busy"},  32'(o_busy),  32'd1);
            check({tag, " done ready"}, 32'(o_ready), 32'd0);
            cyc++;
            @(posedge i_clk); #1;
            @(negedge i_clk);
            check({tag, " back idle"},  32'(o_busy),  32'd0);
            check({tag, " done pulse"}, 32'(o_done),  32'd0);
            check({tag, " left over"},  32'(exp_q.size()), 32'd0);
            if (mode == 0) check({tag, " total cycles"}, 32'(cyc), 32'd75);
        end
    endtask

    vec_t tbl[9];

    initial begin
        i_rst    = 1'b1;
        i_start  = 1'b0;
        i_valid  = 1'b0;
        i_data   = '0;
        i_a_full = '0;
        i_b_full = 1'b0;

        //            rst start vld a_full  b_full rdy bval busy clr done
        tbl[0] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int v = 0; v < 9; v++) begin
            @(posedge i_clk); #1;
            i_rst    = tbl[v].rst;
            i_start  = tbl[v].start;
            i_valid  = tbl[v].valid;
            i_a_full = tbl[v].a_full;
            i_b_full = tbl[v].b_full;
            i_data   = DW'(8'hA0 + v);
            @(negedge i_clk);
            check($sformatf("vec%0d ready", v),   32'(o_ready),   32'(tbl[v].ready));
            check($sformatf("vec%0d b_valid", v), 32'(o_b_valid), 32'(tbl[v].b_valid));
            check($sformatf("vec%0d a_valid", v), 32'(o_a_valid), 32'd0);
            check($sformatf("vec%0d busy", v),    32'(o_busy),    32'(tbl[v].busy));
            check($sformatf("vec%0d clr", v),     32'(o_clr),     32'(tbl[v].clr));
            check($sformatf("vec%0d done", v),    32'(o_done),    32'(tbl[v].done));
            check($sformatf("vec%0d b data", v),  32'(o_b),       32'(8'hA0 + v));
        end
        i_start  = 1'b0;
        i_valid  = 1'b0;
        i_a_full = '0;

        run_load(0, "basic");
        run_load(1, "stall");
        run_load(2, "bubbles");
        run_load(3, "start busy");
        run_load(5, "unselected full");
        run_load(4, "reset mid");
        run_load(0, "after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
